// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic pipeline-stage register for the five-stage MIPS core. It sits
// between two stages (e.g. EX->MEM or MEM->WB) and carries a packed control /
// address / PC payload beside the instruction word. It provides valid/ready
// flow control, a one-entry skid buffer, synchronous flush with bubble (NOP)
// insertion, and a saturating stall-cycle counter for performance debug.
//
// Storage is a main entry, which drives the outputs straight from flops, and
// a skid entry that absorbs the single payload accepted in the cycle the
// downstream stage stalls. Every output is a flop, so there is no
// combinational path from any input to any output.
//
// Parameters
//   CTRL_W    width of the packed control payload
//   INST_W    width of the instruction field
//   NOP_INST  bubble instruction shown whenever the stage holds nothing
//   CNT_W     width of the stall counter
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush, discards every held entry
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (registered, depends on state only)
//   in_ctrl    in   upstream control payload
//   in_inst    in   upstream instruction
//   out_valid  out  downstream payload valid
//   out_ready  in   downstream accepts (inverse of the stall)
//   out_ctrl   out  held control payload, zero when not valid
//   out_inst   out  held instruction, NOP_INST when not valid
//   occupancy  out  number of held entries (0, 1 or 2)
//   stall_cnt  out  saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                CTRL_W   = 22,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0020),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CTRL_W-1:0] CTRL_ZERO = {CTRL_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Number of held entries for a given state; an illegal encoding reads as 0
  // because the next-state logic steers it back to EMPTY.
  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_HALF:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

  state_e              state_q,     state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [1:0]          occ_q,       occ_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic acc_s;
  logic snd_s;

  // Handshakes are formed from registered ready/valid only, so in_ready never
  // depends combinationally on out_ready.
  always_comb begin
    acc_s = in_valid & in_ready_q;
    snd_s = out_valid_q & out_ready;
  end

  // Next-state and payload movement between the main and skid entries.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_inst_d = main_inst_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      // Flush wins over everything: a same-cycle input is dropped, and a
      // same-cycle send has already been taken by downstream.
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_ZERO;
      main_inst_d = NOP_INST;
      skid_ctrl_d = CTRL_ZERO;
      skid_inst_d = NOP_INST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            state_d     = ST_HALF;
            main_ctrl_d = in_ctrl;
            main_inst_d = in_inst;
          end else begin
            state_d     = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (acc_s && snd_s) begin
            state_d     = ST_HALF;
            main_ctrl_d = in_ctrl;
            main_inst_d = in_inst;
          end else if (acc_s) begin
            // Downstream stalled in the same cycle: park the new payload.
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_inst_d = in_inst;
          end else if (snd_s) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_ZERO;
            main_inst_d = NOP_INST;
          end else begin
            state_d     = ST_HALF;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no acceptance can occur.
          if (snd_s) begin
            state_d     = ST_HALF;
            main_ctrl_d = skid_ctrl_q;
            main_inst_d = skid_inst_q;
            skid_ctrl_d = CTRL_ZERO;
            skid_inst_d = NOP_INST;
          end else begin
            state_d     = ST_FULL;
          end
        end
        default: begin
          // Illegal encoding: recover to a clean empty stage.
          state_d     = ST_EMPTY;
          main_ctrl_d = CTRL_ZERO;
          main_inst_d = NOP_INST;
          skid_ctrl_d = CTRL_ZERO;
          skid_inst_d = NOP_INST;
        end
      endcase
    end
  end

  // Status outputs are precomputed from the next state so they can be flopped.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d == ST_HALF) || (state_d == ST_FULL);
    occ_d       = occ_of(state_d);
  end

  // Stall counter: counts cycles with a valid output refused downstream and
  // sticks at all-ones; flush deliberately leaves it alone.
  always_comb begin
    if (out_valid_q && !out_ready) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, payload and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= CTRL_ZERO;
      main_inst_q <= NOP_INST;
      skid_ctrl_q <= CTRL_ZERO;
      skid_inst_q <= NOP_INST;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_inst_q <= main_inst_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_inst_q <= skid_inst_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_ctrl  = main_ctrl_q;
    out_inst  = main_inst_q;
    occupancy = occ_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. The reference model is a queue of
// accepted-but-undelivered payloads: its size is the expected occupancy, it
// is emptied on flush, and the front entry is the expected output. A second
// instance with a 4-bit stall counter shares all inputs to exercise
// saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int CTRL_W = 22;
  localparam int INST_W = 32;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0020;
  localparam int unsigned MAIN_MAX = (1 << CNT_W) - 1;
  localparam int unsigned SAT_MAX  = (1 << SAT_W) - 1;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              flush     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] in_ctrl   = '0;
  logic [INST_W-1:0] in_inst   = '0;

  logic              in_ready,  s_in_ready;
  logic              out_valid, s_out_valid;
  logic [CTRL_W-1:0] out_ctrl,  s_out_ctrl;
  logic [INST_W-1:0] out_inst,  s_out_inst;
  logic [1:0]        occupancy, s_occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [SAT_W-1:0]  s_stall_cnt;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_inst(out_inst),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_inst(in_inst),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_inst(s_out_inst),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_deliv  = 0;

  logic [CTRL_W+INST_W-1:0] exp_q[$];
  bit          exp_ready = 1'b1;
  bit          model_on  = 1'b0;
  int unsigned cnt_main  = 0;
  int unsigned cnt_sat   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare status against the model and pop/compare the
  // payload that the coming edge will deliver.
  always @(negedge clk) begin : monitor
    int sz;
    logic [CTRL_W+INST_W-1:0] item;
    if (model_on && rst_n) begin
      sz = exp_q.size();
      check("occupancy",     64'(occupancy),   64'(sz));
      check("sat_occupancy", 64'(s_occupancy), 64'(sz));
      check("out_valid",     64'(out_valid),   64'(sz != 0));
      check("in_ready",      64'(in_ready),    64'(sz != 2));
      check("stall_cnt",     64'(stall_cnt),   64'(cnt_main));
      check("sat_stall_cnt", 64'(s_stall_cnt), 64'(cnt_sat));
      if (sz == 0) begin
        check("idle_ctrl", 64'(out_ctrl), 64'(0));
        check("idle_inst", 64'(out_inst), 64'(NOP));
      end
      exp_ready = (sz != 2);
      if (sz != 0 && out_ready) begin
        item = exp_q.pop_front();
        n_deliv++;
        check("out_ctrl",     64'(out_ctrl),   64'(item[CTRL_W+INST_W-1:INST_W]));
        check("out_inst",     64'(out_inst),   64'(item[INST_W-1:0]));
        check("sat_out_inst", 64'(s_out_inst), 64'(item[INST_W-1:0]));
      end
      if (sz != 0 && !out_ready) begin
        cnt_main = (cnt_main == MAIN_MAX) ? cnt_main : cnt_main + 1;
        cnt_sat  = (cnt_sat  == SAT_MAX)  ? cnt_sat  : cnt_sat + 1;
      end
    end
  end

  // Stimulus side of the scoreboard: record each accepted payload at its edge.
  always @(posedge clk) begin
    if (model_on && rst_n) begin
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && exp_ready) begin
        exp_q.push_back({in_ctrl, in_inst});
      end
    end
  end

  task automatic step(input bit v, input logic [CTRL_W-1:0] c, input logic [INST_W-1:0] i,
                      input bit ordy, input bit fl);
    in_valid  = v;
    in_ctrl   = c;
    in_inst   = i;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_occ"},       64'(occupancy),   64'(0));
    check({tag, "_out_valid"}, 64'(out_valid),   64'(0));
    check({tag, "_in_ready"},  64'(in_ready),    64'(1));
    check({tag, "_out_ctrl"},  64'(out_ctrl),    64'(0));
    check({tag, "_out_inst"},  64'(out_inst),    64'(NOP));
    check({tag, "_stall"},     64'(stall_cnt),   64'(0));
    check({tag, "_sat_stall"}, 64'(s_stall_cnt), 64'(0));
  endtask

  function automatic void model_clear();
    exp_q.delete();
    cnt_main  = 0;
    cnt_sat   = 0;
    exp_ready = 1'b1;
  endfunction

  int deliv_before;

  initial begin
    @(posedge clk);
    #1;
    // Power-on reset.
    rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    model_clear();
    rst_n    = 1'b1;
    model_on = 1'b1;

    // Reset and idle.
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check_reset_values("idle");

    // Streaming 0x100..0x107 with downstream always ready.
    for (int k = 0; k < 8; k++) step(1'b1, CTRL_W'($urandom), 32'h100 + k, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("stream_stall", 64'(stall_cnt), 64'(0));
    check("stream_deliv", 64'(n_deliv), 64'(8));

    // Back-pressure: A, B land, out_ready low for three cycles, C held until taken.
    deliv_before = n_deliv;
    step(1'b1, 22'h0000A, 32'h200, 1'b1, 1'b0);
    step(1'b1, 22'h0000B, 32'h201, 1'b0, 1'b0);
    check("bp_full_occ", 64'(occupancy), 64'(2));
    check("bp_full_rdy", 64'(in_ready),  64'(0));
    step(1'b1, 22'h0000C, 32'h202, 1'b0, 1'b0);
    step(1'b1, 22'h0000C, 32'h202, 1'b0, 1'b0);
    check("bp_stall3", 64'(stall_cnt), 64'(3));
    step(1'b1, 22'h0000C, 32'h202, 1'b1, 1'b0);
    check("bp_rdy_back", 64'(in_ready), 64'(1));
    step(1'b1, 22'h0000C, 32'h202, 1'b1, 1'b0);
    step(1'b1, 22'h0000D, 32'h203, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_deliv", 64'(n_deliv - deliv_before), 64'(4));

    // Flush while FULL with a same-cycle input that must be dropped.
    step(1'b1, 22'h0000E, 32'h300, 1'b0, 1'b0);
    step(1'b1, 22'h0000F, 32'h301, 1'b0, 1'b0);
    step(1'b1, 22'h00010, 32'h302, 1'b0, 1'b1);
    check("flush_occ",  64'(occupancy), 64'(0));
    check("flush_inst", 64'(out_inst),  64'(NOP));
    check("flush_rdy",  64'(in_ready),  64'(1));
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    step(1'b1, 22'h00011, 32'h400, 1'b0, 1'b0);
    step(1'b1, 22'h00012, 32'h401, 1'b0, 1'b0);
    check("pre_areset_occ", 64'(occupancy), 64'(2));
    in_valid = 1'b0;
    #2;
    model_on = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_values("areset");
    @(posedge clk);
    #1;
    model_clear();
    rst_n    = 1'b1;
    model_on = 1'b1;

    // Saturation: one held entry refused for 20 cycles.
    step(1'b1, 22'h00013, 32'h500, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("sat_stick15", 64'(s_stall_cnt), 64'(15));
    check("main_20",     64'(stall_cnt),   64'(20));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 4) != 0, CTRL_W'($urandom), $urandom,
           ($urandom % 3) != 0, ($urandom % 40) == 0);
    end

    // Drain and confirm nothing was left behind.
    for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
